// File: rtl/reg_arbiter_if.sv
// reg_arbiter_if: requester-side bus of the shared-register arbiter (req/data in, grant/ack/status out).
interface reg_arbiter_if;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;
  logic [1:0]  last;
  modport master (output req, d, input gnt, ack, q, busy, last);
  modport slave (input req, d, output gnt, ack, q, busy, last);
endinterface

// File: rtl/reg_arbiter.sv
// reg_arbiter: 4-way arbiter writing one shared 8-bit register through an IDLE/GRANT/ACK FSM.
// Define REG_ARBITER_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module reg_arbiter (
  input logic          clk,
  input logic          reset,
  reg_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t     r_state, w_state_n;
  logic [3:0] r_gnt, w_gnt_n, r_ack, w_ack_n, w_rot;
  logic [7:0] r_q, w_q_n;
  logic [1:0] r_sel, w_sel_n, r_last, w_last_n, w_base, w_lo, w_win;
  logic       r_busy;
`ifdef REG_ARBITER_RR_EN
  logic [1:0] r_ptr;
  // Rotate so that bit 0 of w_rot is the requester the pointer names.
  assign w_rot = r_ptr == 2'd0 ? bus.req :
                 r_ptr == 2'd1 ? {bus.req[0], bus.req[3:1]} :
                 r_ptr == 2'd2 ? {bus.req[1:0], bus.req[3:2]} :
                                 {bus.req[2:0], bus.req[3]};
  assign w_base = r_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ptr <= '0;
    else if (r_state == ACK) r_ptr <= r_sel + 2'd1;
`else
  assign w_rot  = bus.req;
  assign w_base = '0;
`endif
  assign w_lo  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_win = w_base + w_lo;
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_ack_n   = '0;
    w_q_n     = r_q;
    w_sel_n   = r_sel;
    w_last_n  = r_last;
    case (r_state)
      IDLE: begin
        w_state_n = |bus.req ? GRANT : IDLE;
        w_sel_n   = |bus.req ? w_win : r_sel;
        w_gnt_n   = |bus.req ? 4'b0001 << w_win : 4'b0000;
      end
      GRANT: begin
        w_state_n = bus.req[r_sel] ? ACK : IDLE;
        w_q_n     = bus.req[r_sel] ? bus.d[{r_sel, 3'b000} +: 8] : r_q;
        w_ack_n   = bus.req[r_sel] ? r_gnt : 4'b0000;
        w_gnt_n   = bus.req[r_sel] ? r_gnt : 4'b0000;
      end
      ACK: begin
        w_state_n = IDLE;
        w_gnt_n   = '0;
        w_last_n  = r_sel;
      end
      default: begin
        w_state_n = IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= '0;
      r_sel   <= '0;
      r_last  <= 2'd3;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_ack   <= w_ack_n;
      r_q     <= w_q_n;
      r_sel   <= w_sel_n;
      r_last  <= w_last_n;
      r_busy  <= w_state_n != IDLE;
    end
  assign bus.gnt  = r_gnt;
  assign bus.ack  = r_ack;
  assign bus.q    = r_q;
  assign bus.busy = r_busy;
  assign bus.last = r_last;
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_gnt));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(r_ack));
  a_ack_in_gnt: assert property (@(posedge clk) disable iff (!reset) (r_ack & ~r_gnt) == 4'b0000);
endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: randomized and directed transactions against a transaction-level arbitration model with an ack scoreboard.
module tb_reg_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  reg_arbiter_if bus ();
  reg_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int m_ptr = 0;
  logic [1:0] m_last = 2'd3;
  logic [7:0] m_q = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Winner chosen from the policy rules: first set bit scanning from the pointer (RR) or from 0 (fixed).
  function automatic int pick(input logic [3:0] r);
    int idx;
    for (int k = 0; k < 4; k++) begin
`ifdef REG_ARBITER_RR_EN
      idx = (m_ptr + k) % 4;
`else
      idx = k;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction
  always @(negedge clk) begin
    int e;
    if (reset && bus.ack != 4'b0000) begin
      if (exp_q.size() == 0) chk("ack_unexpected", {28'b0, bus.ack}, 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("ack_idx", {28'b0, bus.ack}, 32'h1 << (e >> 8));
        chk("ack_q", {24'b0, bus.q}, e & 255);
        chk("ack_gnt", {28'b0, bus.gnt}, 32'h1 << (e >> 8));
      end
    end
  end
  task automatic model_reset();
    m_ptr = 0;
    m_last = 2'd3;
    m_q = 8'h00;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.req = '0;
    @(negedge clk);
    chk("rst_q", {24'b0, bus.q}, 0);
    chk("rst_gnt", {28'b0, bus.gnt}, 0);
    chk("rst_ack", {28'b0, bus.ack}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_last", {30'b0, bus.last}, 3);
    model_reset();
    reset = 1'b1;
  endtask
  task automatic do_txn(input logic [3:0] r, input logic wd, input logic [31:0] dv, input logic abort);
    int w;
    logic [3:0] oh;
    logic [31:0] dn;
    bus.req = r;
    bus.d = $urandom;
    w = pick(r);
    @(negedge clk);
    if (w < 0) begin
      chk("idle_gnt", {28'b0, bus.gnt}, 0);
      chk("idle_busy", {31'b0, bus.busy}, 0);
      return;
    end
    oh = 4'b0001 << w;
    chk("grant_gnt", {28'b0, bus.gnt}, {28'b0, oh});
    chk("grant_busy", {31'b0, bus.busy}, 1);
    dn = $urandom;
    dn[8*w +: 8] = dv[8*w +: 8];
    bus.d = dn;
    bus.req = (4'($urandom) & ~oh) | (wd ? 4'b0000 : oh);
    if (!wd) begin
      m_q = dv[8*w +: 8];
      exp_q.push_back(w * 256 + int'(m_q));
    end
    @(negedge clk);
    if (wd) begin
      chk("wd_gnt", {28'b0, bus.gnt}, 0);
      chk("wd_busy", {31'b0, bus.busy}, 0);
      chk("wd_q", {24'b0, bus.q}, {24'b0, m_q});
      chk("wd_last", {30'b0, bus.last}, {30'b0, m_last});
      return;
    end
    chk("ack_gnt_hold", {28'b0, bus.gnt}, {28'b0, oh});
    bus.d = $urandom;
    bus.req = 4'($urandom);
    if (abort) begin
      #2 reset = 1'b0;
      #1;
      chk("abort_ack", {28'b0, bus.ack}, 0);
      chk("abort_gnt", {28'b0, bus.gnt}, 0);
      chk("abort_busy", {31'b0, bus.busy}, 0);
      chk("abort_q", {24'b0, bus.q}, 0);
      model_reset();
      bus.req = '0;
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    m_last = 2'(w);
    m_ptr = (w + 1) % 4;
    @(negedge clk);
    chk("done_busy", {31'b0, bus.busy}, 0);
    chk("done_gnt", {28'b0, bus.gnt}, 0);
    chk("done_ack", {28'b0, bus.ack}, 0);
    chk("done_last", {30'b0, bus.last}, {30'b0, m_last});
    chk("done_q", {24'b0, bus.q}, {24'b0, m_q});
  endtask
  initial begin
    logic [3:0] r;
    bus.req = '0;
    bus.d = '0;
    do_reset();
    do_txn(4'b0100, 1'b0, 32'h00A5_0000, 1'b0);
    do_reset();
    do_txn(4'b1111, 1'b0, $urandom, 1'b0);
    do_txn(4'b1110, 1'b0, $urandom, 1'b0);
    do_txn(4'b1100, 1'b0, $urandom, 1'b0);
    do_txn(4'b1000, 1'b0, $urandom, 1'b0);
    do_reset();
    repeat (4) do_txn(4'b0011, 1'b0, $urandom, 1'b0);
    do_txn(4'b0010, 1'b1, $urandom, 1'b0);
    do_txn(4'b0000, 1'b0, $urandom, 1'b0);
    do_txn(4'b0001, 1'b0, $urandom, 1'b1);
    repeat (150) begin
      r = 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = 4'b0000;
      do_txn(r, $urandom_range(0, 5) == 0, $urandom, 1'b0);
    end
    do_txn(4'b1010, 1'b0, $urandom, 1'b1);
    repeat (20) do_txn(4'($urandom), 1'b0, $urandom, 1'b0);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port `req`, input, 4 bits: `req[i]` high = requester i wants to write the shared register.
REQ-004 The block SHALL have port `d`, input, 32 bits: requester i's write data on `d[8*i+7:8*i]`.
REQ-005 The block SHALL have port `gnt`, output, 4 bits: one-hot grant, or all-zero.
REQ-006 The block SHALL have port `ack`, output, 4 bits: one-cycle pulse to requester i when its write has landed in `q`.
REQ-007 The block SHALL have port `q`, output, 8 bits: shared 8-bit register contents.
REQ-008 The block SHALL have port `busy`, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-009 The block SHALL have port `last`, output, 2 bits: index of the most recently acknowledged requester.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and ACK, with all outputs registered.
REQ-011 In IDLE, with `req` nonzero, the block SHALL select winner w per REQ-017/018, set `gnt` to one-hot w and go to GRANT at the next edge.
REQ-012 In IDLE with `req` = 0, the block SHALL stay in IDLE with `gnt` = 0.
REQ-013 In GRANT, if `req[w]` = 1, the block SHALL load `q` with `d` slice w, set `ack[w]` = 1 and go to ACK at the next edge.
REQ-014 In GRANT, if `req[w]` = 0 (withdrawn), the block SHALL:
- leave `q` unchanged;
- generate no ack;
- clear `gnt`;
- not update the pointer or `last`;
- go to IDLE.
REQ-015 In ACK, the block SHALL:
- hold `ack[w]` high for exactly this cycle;
- at the next edge, clear `ack` and `gnt`;
- set `last` to w;
- advance the pointer to (w+1) mod 4;
- go to IDLE.
REQ-016 Latency SHALL be:
- request sampled in IDLE at cycle 0;
- `gnt` high in cycles 1–2;
- `q` updated and `ack` high in cycle 2;
- back in IDLE in cycle 3.
- Maximum throughput SHALL be one write per 3 cycles.
REQ-017 Round-robin arbitration (macro defined) SHALL scan `req` starting at the pointer index, in order pointer, pointer+1, … mod 4, and grant the first set bit.
REQ-018 Fixed-priority arbitration (macro undefined) SHALL grant the lowest set index; the pointer register SHALL NOT exist.
REQ-019 Changes to `req` bits other than w during GRANT/ACK SHALL have no effect until the next IDLE.
REQ-020 A requester still holding `req` high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-021 `gnt` and `ack` SHALL never have more than one bit set, and `ack` SHALL only be set on the bit also set in `gnt`.
REQ-022 `d` SHALL be sampled only at the GRANT→ACK edge; its value at any other time SHALL NOT affect `q`.

Reset
REQ-023 `reset` = 0 SHALL immediately, regardless of `clk`, force:
- state IDLE;
- `q` = 8'h00;
- `gnt` = 0;
- `ack` = 0;
- `busy` = 0;
- `last` = 2'd3;
- pointer = 0.
REQ-024 Reset asserted mid-transaction (GRANT or ACK) SHALL abort it with no ack and `q` = 8'h00.
REQ-025 The first arbitration SHALL occur on the first rising edge with `reset` = 1.

Configuration
REQ-026 Macro `REG_ARBITER_RR_EN` SHALL control the arbitration policy:
- defined: round-robin per REQ-017;
- undefined: fixed priority per REQ-018.
- Interface and FSM timing SHALL be identical in both builds.

Verification
REQ-027 Reset then a single request SHALL complete as follows:
- stimulus: `reset` low then high; `req` = 4'b0100 with `d[23:16]` = 8'hA5;
- response: `gnt` = 4'b0100 in cycles 1–2; `q` = 8'hA5 and `ack` = 4'b0100 in cycle 2; `last` = 2 after; `busy` low in cycle 3.
REQ-028 All four requests held continuously SHALL be served as follows:
- stimulus: `req` = 4'b1111 held, each requester dropping `req` in the cycle after its ack;
- RR build: grants 0,1,2,3 in order, one every 3 cycles;
- fixed build: grant order 0,1,2,3 by priority.
REQ-029 Requester 0 re-requesting SHALL not starve requester 1 in the RR build:
- stimulus: `req[0]` and `req[1]` held high for 12 cycles;
- RR build: grants alternate 0,1,0,1;
- fixed build: grant 0 repeatedly, requester 1 starved.
REQ-030 A withdrawn request SHALL be dropped cleanly:
- stimulus: `req` = 4'b0010, deasserted in the GRANT cycle;
- response: no ack; `q` unchanged; `last` unchanged; IDLE the next cycle.
REQ-031 Reset asserted during ACK SHALL clear everything at once:
- stimulus: `reset` driven low asynchronously mid-cycle in ACK;
- response: `ack`, `gnt`, `busy` and `q` go to 0 immediately, without waiting for a `clk` edge.
